// File: rtl/pad_mux_sequencer.sv
// Glitch-free run-time pad mux/config sequencer: tristate, settle, switch, settle, release.
// Optional build macro PADSEQ_LOCK_EN adds a sticky lock_i that rejects all new requests.
module pad_mux_sequencer #(
  parameter int N_IO          = 48,
  parameter int NBIT_PADMUX   = 2,
  parameter int NBIT_PADCFG   = 6,
  parameter int SETTLE_CYCLES = 4,
  localparam int IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1
) (
  input  logic                        ref_clk_i,
  input  logic                        rst_ni,
`ifdef PADSEQ_LOCK_EN
  input  logic                        lock_i,
`endif
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [IDX_W-1:0]            req_idx_i,
  input  logic [NBIT_PADMUX-1:0]      req_mux_i,
  input  logic [NBIT_PADCFG-1:0]      req_cfg_i,
  output logic [N_IO*NBIT_PADMUX-1:0] pad_mux_o,
  output logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_o,
  output logic [N_IO-1:0]             pad_hold_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SWITCH,
    RELEASE
  } state_e;

  localparam logic [IDX_W:0] N_IO_L = (IDX_W + 1)'(N_IO);
  localparam logic [7:0]     S_LAST = 8'(SETTLE_CYCLES - 1);

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBIT_PADMUX-1:0] cap_mux_q, cap_mux_d;
  logic [NBIT_PADCFG-1:0] cap_cfg_q, cap_cfg_d;
  logic [N_IO-1:0][NBIT_PADMUX-1:0] mux_q, mux_d;
  logic [N_IO-1:0][NBIT_PADCFG-1:0] cfg_q, cfg_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic reject;

`ifdef PADSEQ_LOCK_EN
  logic lock_q;

  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_q <= 1'b0;
    else         lock_q <= lock_q | lock_i;
  end

  assign reject = ({1'b0, req_idx_i} >= N_IO_L) || lock_q;
`else
  assign reject = ({1'b0, req_idx_i} >= N_IO_L);
`endif

  always_ff @(posedge ref_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      cap_mux_q <= '0;
      cap_cfg_q <= '0;
      mux_q     <= '0;
      cfg_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cap_mux_q <= cap_mux_d;
      cap_cfg_q <= cap_cfg_d;
      mux_q     <= mux_d;
      cfg_q     <= cfg_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cap_mux_d = cap_mux_q;
    cap_cfg_d = cap_cfg_q;
    mux_d     = mux_q;
    cfg_d     = cfg_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (reject) begin
            err_d = 1'b1;
          end else if (mux_q[req_idx_i] == req_mux_i) begin
            // Same source: config change cannot glitch the mux, skip the hold
            cfg_d[req_idx_i] = req_cfg_i;
            done_d           = 1'b1;
          end else begin
            state_d   = HOLD;
            cnt_d     = '0;
            idx_d     = req_idx_i;
            cap_mux_d = req_mux_i;
            cap_cfg_d = req_cfg_i;
          end
        end
      end
      HOLD: begin
        if (cnt_q == S_LAST) begin
          state_d = SWITCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SWITCH: begin
        mux_d[idx_q] = cap_mux_q;
        cfg_d[idx_q] = cap_cfg_q;
        state_d      = RELEASE;
        cnt_d        = '0;
      end
      RELEASE: begin
        if (cnt_q == S_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the pad under sequence is ever forced tristate
  always_comb begin
    pad_hold_o = '0;
    if (state_q != IDLE) pad_hold_o[idx_q] = 1'b1;
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign pad_mux_o   = mux_q;
  assign pad_cfg_o   = cfg_q;

endmodule
